if_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end with a decoupling prefetch queue. It replaces the single-entry PC/IF register path with a pipelined memory request/response interface and supports up to DEPTH outstanding fetches. It delivers instructions in order to the IF/ID boundary and discards wrong-path fetches on branch/jalr redirect from EX. It sits between instruction memory and IF_ID_pipeline.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/if_prefetch_unit_inst_fifo.sv | 61 ++++++
 rtl/if_prefetch_unit.sv | 126 ++++++++++++
 tb/tb_if_prefetch_unit.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default reset PC and the NOP encoding used by decode for bubbles.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/if_prefetch_unit_inst_fifo.sv
// Synchronous FIFO for fetched instructions: registered head, occupancy count,
// synchronous flush that empties the queue without touching stored data.
module inst_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end with credit-limited pipelined memory requests and a prefetch queue.
// Optional IF_PREFETCH_PERF_EN adds redirect and empty-cycle performance counters.
module if_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned INST_WIDTH      = 32,
  parameter int unsigned INST_ADDR_WIDTH = 32,
  parameter int unsigned DEPTH           = 4,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = INST_ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  output logic                       imem_req_valid,
  output logic [INST_ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [INST_WIDTH-1:0]      imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  output logic                       out_valid,
  output logic [INST_WIDTH-1:0]      out_inst,
  output logic [INST_ADDR_WIDTH-1:0] out_pc,
  output logic [INST_ADDR_WIDTH-1:0] out_pc_plus_4,
  input  logic                       out_ready
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]                perf_redirects,
  output logic [31:0]                perf_empty_cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [INST_ADDR_WIDTH-1:0] PC_STEP = INST_ADDR_WIDTH'(4);

  logic [INST_ADDR_WIDTH-1:0] fetch_pc;
  logic [INST_ADDR_WIDTH-1:0] head_pc;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           inflight;
  logic [CNT_W-1:0]           drop_cnt;
  logic [CNT_W-1:0]           inflight_after_rsp;
  logic [OCC_W-1:0]           occupancy;
  logic                       req_fire;
  logic                       rsp_take;
  logic                       rsp_push;
  logic                       pop;
  logic                       fifo_empty;

  // Queued plus outstanding fetches form the credit pool; it never exceeds DEPTH.
  assign occupancy      = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = !cpu_rst && !redirect_valid && (occupancy < OCC_W'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are protocol violations and are ignored.
  assign rsp_take           = imem_rsp_valid && (inflight != '0);
  assign rsp_push           = rsp_take && !redirect_valid && (drop_cnt == '0);
  assign inflight_after_rsp = inflight - CNT_W'(rsp_take);

  assign pop = out_valid && out_ready && !redirect_valid;

  inst_fifo #(
    .WIDTH (INST_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (cpu_clk),
    .rst       (cpu_rst),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_data (imem_rsp_data),
    .pop       (pop),
    .head      (out_inst),
    .empty     (fifo_empty),
    .count     (count)
  );

  // Redirect restarts both PCs; everything still in flight becomes wrong-path and is dropped.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      head_pc  <= redirect_pc;
      inflight <= inflight_after_rsp;
      drop_cnt <= inflight_after_rsp;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (pop) begin
        head_pc <= head_pc + PC_STEP;
      end
      inflight <= inflight_after_rsp + CNT_W'(req_fire);
      if (rsp_take && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  assign out_valid     = !fifo_empty;
  assign out_pc        = head_pc;
  assign out_pc_plus_4 = head_pc + PC_STEP;

`ifdef IF_PREFETCH_PERF_EN
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      perf_redirects    <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (redirect_valid) begin
        perf_redirects <= perf_redirects + 32'd1;
      end
      if (!out_valid) begin
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: in-order memory model with configurable latency,
// epoch-tagged prefetch reference model, scenario tasks plus randomized traffic.
module tb_if_prefetch_unit;

  localparam int unsigned IW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic [IW-1:0] out_inst;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc_plus_4;
  logic          out_ready;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0]   perf_redirects;
  logic [31:0]   perf_empty_cycles;
`endif

  always #5 cpu_clk = ~cpu_clk;

  if_prefetch_unit #(
    .INST_WIDTH      (IW),
    .INST_ADDR_WIDTH (AW),
    .DEPTH           (DEPTH),
    .RESET_PC        (RPC)
  ) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pc_plus_4  (out_pc_plus_4),
    .out_ready      (out_ready)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_redirects    (perf_redirects),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
    int          epoch;
  } mreq_t;

  // Reference state: memory pipeline (all outstanding fetches) and the instruction stream queue.
  mreq_t       mq[$];
  logic [31:0] pq[$];
  logic [31:0] m_fetch = RPC;
  logic [31:0] m_head  = RPC;
  int          epoch = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  bit          live = 1'b0;
  int          m_perf_red = 0;
  int          m_perf_empty = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit exp_req_valid();
    return (cpu_rst === 1'b0) && (redirect_valid === 1'b0) &&
           ((pq.size() + mq.size()) < int'(DEPTH));
  endfunction

  // Memory + reference model: update on each edge, then drive the next response.
  initial begin : model
    mreq_t it;
    bit    m_fire;
    bit    m_pop;
    bit    m_keep;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge cpu_clk);
      if (cpu_rst === 1'b1) begin
        mq.delete();
        pq.delete();
        m_fetch = RPC;
        m_head = RPC;
        epoch = 0;
        last_due = 0;
        m_perf_red = 0;
        m_perf_empty = 0;
        live = 1'b1;
      end else if (live) begin
        m_fire = exp_req_valid() && (imem_req_ready === 1'b1);
        m_pop  = (pq.size() > 0) && (out_ready === 1'b1) && (redirect_valid === 1'b0);
        m_keep = 1'b0;
        if (redirect_valid === 1'b1) m_perf_red++;
        if (pq.size() == 0) m_perf_empty++;
        if ((imem_rsp_valid === 1'b1) && (mq.size() > 0)) begin
          it = mq.pop_front();
          m_keep = (it.epoch == epoch) && (redirect_valid === 1'b0);
        end
        if (redirect_valid === 1'b1) begin
          pq.delete();
          epoch++;
          m_fetch = redirect_pc;
          m_head = redirect_pc;
        end else begin
          if (m_pop) begin
            void'(pq.pop_front());
            m_head = m_head + 32'd4;
          end
          if (m_keep) pq.push_back(it.addr);
          if (m_fire) begin
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            mq.push_back('{due: last_due, addr: m_fetch, epoch: epoch});
            m_fetch = m_fetch + 32'd4;
          end
        end
      end
      cyc++;
      #1;
      if ((mq.size() > 0) && (mq[0].due <= cyc)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memfn(mq[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  end

  // Scoreboard: every cycle the DUT outputs must match the reference model.
  always @(negedge cpu_clk) begin
    if (live) begin
      n_tests++;
      if (out_valid !== (pq.size() > 0)) begin
        n_fail++;
        $display("FAIL sb_out_valid cyc=%0d got %b expected %b", cyc, out_valid, pq.size() > 0);
      end
      n_tests++;
      if (out_pc !== m_head) begin
        n_fail++;
        $display("FAIL sb_out_pc cyc=%0d got %h expected %h", cyc, out_pc, m_head);
      end
      n_tests++;
      if (out_pc_plus_4 !== m_head + 32'd4) begin
        n_fail++;
        $display("FAIL sb_out_pc_plus_4 cyc=%0d got %h expected %h", cyc, out_pc_plus_4, m_head + 32'd4);
      end
      if (pq.size() > 0) begin
        n_tests++;
        if (out_inst !== memfn(pq[0])) begin
          n_fail++;
          $display("FAIL sb_out_inst cyc=%0d got %h expected %h", cyc, out_inst, memfn(pq[0]));
        end
      end
      n_tests++;
      if (imem_req_valid !== exp_req_valid()) begin
        n_fail++;
        $display("FAIL sb_req_valid cyc=%0d got %b expected %b", cyc, imem_req_valid, exp_req_valid());
      end
      if (exp_req_valid()) begin
        n_tests++;
        if (imem_req_addr !== m_fetch) begin
          n_fail++;
          $display("FAIL sb_req_addr cyc=%0d got %h expected %h", cyc, imem_req_addr, m_fetch);
        end
      end
`ifdef IF_PREFETCH_PERF_EN
      n_tests++;
      if ((perf_redirects !== 32'(m_perf_red)) || (perf_empty_cycles !== 32'(m_perf_empty))) begin
        n_fail++;
        $display("FAIL sb_perf cyc=%0d got %0d/%0d expected %0d/%0d", cyc,
                 perf_redirects, perf_empty_cycles, m_perf_red, m_perf_empty);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    cpu_rst = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    tick();
    tick();
    @(negedge cpu_clk);
    n_tests++;
    if ((imem_req_valid !== 1'b0) || (out_valid !== 1'b0) || (out_inst !== 32'h0) ||
        (out_pc !== RPC) || (out_pc_plus_4 !== RPC + 32'd4)) begin
      n_fail++;
      $display("FAIL reset_values got rv=%b ov=%b inst=%h pc=%h pc4=%h expected 0/0/0/%h/%h",
               imem_req_valid, out_valid, out_inst, out_pc, out_pc_plus_4, RPC, RPC + 32'd4);
    end
    tick();
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    n_tests++;
    if ((imem_req_valid !== 1'b1) || (imem_req_addr !== RPC) || (out_valid !== 1'b0)) begin
      n_fail++;
      $display("FAIL first_request got rv=%b addr=%h ov=%b expected 1/%h/0",
               imem_req_valid, imem_req_addr, out_valid, RPC);
    end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 14; k++) begin
      tick();
      @(negedge cpu_clk);
      n_tests++;
      if ((imem_req_valid !== 1'b1) || (imem_req_addr !== 32'(4 * k))) begin
        n_fail++;
        $display("FAIL stream_req k=%0d got %b/%h expected 1/%h", k, imem_req_valid, imem_req_addr, 32'(4 * k));
      end
      if (k >= 2) begin
        n_tests++;
        if ((out_valid !== 1'b1) || (out_pc !== 32'(4 * (k - 2)))) begin
          n_fail++;
          $display("FAIL stream_out k=%0d got %b/%h expected 1/%h", k, out_valid, out_pc, 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] h;
    tick();
    out_ready = 1'b0;
    h = m_head;
    repeat (10) tick();
    @(negedge cpu_clk);
    n_tests++;
    if ((imem_req_valid !== 1'b0) || (out_valid !== 1'b1) || (out_pc !== h) ||
        (imem_req_addr !== h + 32'(4 * DEPTH))) begin
      n_fail++;
      $display("FAIL backpressure_full got rv=%b ov=%b pc=%h addr=%h expected 0/1/%h/%h",
               imem_req_valid, out_valid, out_pc, imem_req_addr, h, h + 32'(4 * DEPTH));
    end
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge cpu_clk);
      n_tests++;
      if ((out_valid !== 1'b1) || (out_pc !== h + 32'(4 * k))) begin
        n_fail++;
        $display("FAIL backpressure_release k=%0d got %b/%h expected 1/%h", k, out_valid, out_pc, h + 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect_drop();
    int waited;
    bit seen;
    lat = 3;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge cpu_clk);
    n_tests++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_no_issue got %b expected 0", imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge cpu_clk);
    n_tests++;
    if ((out_valid !== 1'b0) || (imem_req_valid !== 1'b1) || (imem_req_addr !== 32'h100)) begin
      n_fail++;
      $display("FAIL redirect_next got ov=%b rv=%b addr=%h expected 0/1/00000100", out_valid, imem_req_valid, imem_req_addr);
    end
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 20) begin
      tick();
      waited++;
      @(negedge cpu_clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen || (waited != 4) || (out_pc !== 32'h100) || (out_inst !== memfn(32'h100))) begin
      n_fail++;
      $display("FAIL redirect_first_out got seen=%b wait=%0d pc=%h inst=%h expected 1/4/00000100/%h",
               seen, waited, out_pc, out_inst, memfn(32'h100));
    end
    lat = 1;
  endtask

  task automatic test_redirect_collision();
    lat = 1;
    do_reset();
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge cpu_clk);
    n_tests++;
    if ((out_valid !== 1'b1) || (imem_rsp_valid !== 1'b1)) begin
      n_fail++;
      $display("FAIL collision_setup got ov=%b rsp=%b expected 1/1", out_valid, imem_rsp_valid);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge cpu_clk);
    n_tests++;
    if ((out_valid !== 1'b0) || (out_pc !== 32'h200) || (imem_req_addr !== 32'h200)) begin
      n_fail++;
      $display("FAIL collision_after got ov=%b pc=%h addr=%h expected 0/00000200/00000200", out_valid, out_pc, imem_req_addr);
    end
    tick();
    tick();
    @(negedge cpu_clk);
    n_tests++;
    if ((out_valid !== 1'b1) || (out_pc !== 32'h200) || (out_inst !== memfn(32'h200))) begin
      n_fail++;
      $display("FAIL collision_new_stream got %b/%h/%h expected 1/00000200/%h", out_valid, out_pc, out_inst, memfn(32'h200));
    end
  endtask

  task automatic test_req_stall();
    lat = 1;
    do_reset();
    repeat (4) tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge cpu_clk);
      n_tests++;
      if ((imem_req_valid !== 1'b1) || (imem_req_addr !== 32'h10)) begin
        n_fail++;
        $display("FAIL stall_addr i=%0d got %b/%h expected 1/00000010", i, imem_req_valid, imem_req_addr);
      end
      if (i < 4) tick();
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain got %b expected 0", out_valid);
    end
    tick();
    imem_req_ready = 1'b1;
    tick();
    tick();
    @(negedge cpu_clk);
    n_tests++;
    if ((out_valid !== 1'b1) || (out_pc !== 32'h10)) begin
      n_fail++;
      $display("FAIL stall_resume got %b/%h expected 1/00000010", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      @(negedge cpu_clk);
      n_tests++;
      if ((out_valid !== 1'b1) || (out_pc !== e) || (out_pc_plus_4 !== e + 32'd4)) begin
        n_fail++;
        $display("FAIL wrap k=%0d got %b/%h/%h expected 1/%h/%h", k, out_valid, out_pc, out_pc_plus_4, e, e + 32'd4);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit seen;
    for (int seg = 0; seg < 4; seg++) begin
      lat = int'($urandom_range(1, 4));
      if (seg == 2) begin
        cpu_rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        cpu_rst = 1'b0;
      end
      for (int i = 0; i < 150; i++) begin
        tick();
        imem_req_ready = ($urandom_range(0, 9) < 8);
        out_ready      = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 24) == 0);
        redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
      end
    end
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      @(negedge cpu_clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL random_progress got out_valid=0 for 12 cycles expected 1");
    end
  endtask

`ifdef IF_PREFETCH_PERF_EN
  task automatic test_perf();
    lat = 1;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h400 + 32'(r * 64);
      tick();
      redirect_valid = 1'b0;
    end
    repeat (4) tick();
    @(negedge cpu_clk);
    n_tests++;
    if ((perf_redirects !== 32'd3) || (perf_empty_cycles !== 32'(m_perf_empty))) begin
      n_fail++;
      $display("FAIL perf_counters got %0d/%0d expected 3/%0d", perf_redirects, perf_empty_cycles, m_perf_empty);
    end
  endtask
`endif

  initial begin
    cpu_rst = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_collision();
    test_req_stall();
    test_wrap();
    test_random();
`ifdef IF_PREFETCH_PERF_EN
    test_perf();
`endif
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
